// File: rtl/flash_fsm.sv
// Audio sample fetcher: on each sample tick, read one 32-bit flash word over Avalon-MM and
// present one 16-bit half. A word/half pointer then steps forwards or backwards with wrap-around.
module flash_fsm #(
    parameter logic [22:0] MAX_ADDR = 23'h7FFFF
) (
    input  logic        CLK50MHZ,
    input  logic        reset,
    input  logic        CLK22KHZ,
    input  logic        pause,
    input  logic        direction,
    input  logic        flash_mem_waitrequest,
    input  logic        flash_mem_readdatavalid,
    input  logic [31:0] flash_mem_readdata,
    output logic        flash_mem_read,
    output logic [3:0]  flash_mem_byteenable,
    output logic [22:0] flash_mem_address,
    output logic [15:0] data_out
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWaitData
    } state_e;

    state_e      state_q, state_d;
    logic        read_q, read_d;
    logic [22:0] addr_q, addr_d;
    logic        half_q, half_d;
    logic [15:0] data_q, data_d;

    logic [22:0] addr_adv;
    logic        half_adv;

    // Pointer step: the half always toggles; the word address moves only when leaving the
    // last half in the current direction. Wrap is by explicit compare, not by overflow.
    always_comb begin
        addr_adv = addr_q;
        half_adv = ~half_q;
        if (direction) begin
            if (half_q) begin
                addr_adv = (addr_q == MAX_ADDR) ? 23'd0 : addr_q + 23'd1;
            end
        end else begin
            if (!half_q) begin
                addr_adv = (addr_q == 23'd0) ? MAX_ADDR : addr_q - 23'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        read_d  = read_q;
        addr_d  = addr_q;
        half_d  = half_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                read_d = 1'b0;
                if (CLK22KHZ && !pause) begin
                    state_d = StRead;
                    read_d  = 1'b1;
                end
            end
            StRead: begin
                read_d = 1'b1;
                if (!flash_mem_waitrequest) begin
                    state_d = StWaitData;
                    read_d  = 1'b0;
                end
            end
            StWaitData: begin
                read_d = 1'b0;
                if (flash_mem_readdatavalid) begin
                    data_d  = half_q ? flash_mem_readdata[31:16] : flash_mem_readdata[15:0];
                    addr_d  = addr_adv;
                    half_d  = half_adv;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                read_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK50MHZ) begin
        if (reset) begin
            state_q <= StIdle;
            read_q  <= 1'b0;
            addr_q  <= 23'd0;
            half_q  <= 1'b0;
            data_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            half_q  <= half_d;
            data_q  <= data_d;
        end
    end

    assign flash_mem_read       = read_q;
    assign flash_mem_address    = addr_q;
    assign flash_mem_byteenable = 4'b1111;
    assign data_out             = data_q;

endmodule

// File: tb/tb_flash_fsm.sv
// Directed bench for flash_fsm: inputs driven and outputs sampled on the falling clock edge.
module tb_flash_fsm;

    localparam logic [22:0] MaxAddr = 23'h7FFFF;

    logic        clk = 1'b0;
    logic        reset, tick, pause, direction, wreq, rdv;
    logic [31:0] rdata;
    logic        rd;
    logic [3:0]  be;
    logic [22:0] addr;
    logic [15:0] dout;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;

    flash_fsm #(.MAX_ADDR(MaxAddr)) dut (
        .CLK50MHZ                (clk),
        .reset                   (reset),
        .CLK22KHZ                (tick),
        .pause                   (pause),
        .direction               (direction),
        .flash_mem_waitrequest   (wreq),
        .flash_mem_readdatavalid (rdv),
        .flash_mem_readdata      (rdata),
        .flash_mem_read          (rd),
        .flash_mem_byteenable    (be),
        .flash_mem_address       (addr),
        .data_out                (dout)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    // Tick is high across exactly one rising edge (edge 0); returns just after it.
    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick = 1'b0; pause = 1'b0; direction = 1'b1;
        wreq = 1'b0; rdv = 1'b0; rdata = 32'h0;
        cyc();
        n_checks++; if (be !== 4'b1111) begin n_fail++; $display("FAIL rst_be_in_reset: got %h want f", be); end
        cyc();
        reset = 1'b0;
        n_checks++; if (rd !== 1'b0) begin n_fail++; $display("FAIL rst_read: got %b want 0", rd); end
        n_checks++; if (addr !== 23'd0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", addr); end
        n_checks++; if (dout !== 16'h0) begin n_fail++; $display("FAIL rst_dout: got %h want 0", dout); end
        cyc();
        n_checks++; if (rd !== 1'b0) begin n_fail++; $display("FAIL rst_idle_read: got %b want 0", rd); end
    endtask

    task automatic test_forward();
        logic [22:0] exp_a [4];
        logic [15:0] exp_d [4];
        logic [15:0] prev;
        exp_a = '{23'd0, 23'd0, 23'd1, 23'd1};
        exp_d = '{16'h1234, 16'h7F7F, 16'h1234, 16'h7F7F};
        prev = 16'h0000;
        direction = 1'b1; wreq = 1'b0; rdv = 1'b1; rdata = 32'h7F7F_1234;
        for (int i = 0; i < 4; i++) begin
            pulse_tick();
            n_checks++; if (rd !== 1'b1) begin n_fail++; $display("FAIL fwd_read_e0[%0d]: got %b want 1", i, rd); end
            n_checks++; if (addr !== exp_a[i]) begin n_fail++; $display("FAIL fwd_addr[%0d]: got %h want %h", i, addr, exp_a[i]); end
            cyc();
            n_checks++; if (rd !== 1'b0) begin n_fail++; $display("FAIL fwd_read_e1[%0d]: got %b want 0", i, rd); end
            n_checks++; if (dout !== prev) begin n_fail++; $display("FAIL fwd_dout_e1[%0d]: got %h want %h", i, dout, prev); end
            cyc();
            n_checks++; if (dout !== exp_d[i]) begin n_fail++; $display("FAIL fwd_dout_e2[%0d]: got %h want %h", i, dout, exp_d[i]); end
            prev = exp_d[i];
            repeat (3) cyc();
        end
        n_checks++; if (addr !== 23'd2) begin n_fail++; $display("FAIL fwd_addr_end: got %h want 2", addr); end
    endtask

    task automatic test_waitrequest();
        wreq = 1'b1; rdv = 1'b0; rdata = 32'hBEEF_CAFE;
        pulse_tick();
        n_checks++; if (rd !== 1'b1) begin n_fail++; $display("FAIL wr_read_start: got %b want 1", rd); end
        for (int k = 0; k < 5; k++) begin
            cyc();
            n_checks++; if (rd !== 1'b1 || addr !== 23'd2) begin
                n_fail++; $display("FAIL wr_hold[%0d]: got read=%b addr=%h want read=1 addr=2", k, rd, addr);
            end
        end
        wreq = 1'b0;
        cyc();
        n_checks++; if (rd !== 1'b0) begin n_fail++; $display("FAIL wr_accept: got %b want 0", rd); end
        repeat (2) cyc();
        n_checks++; if (dout !== 16'h7F7F) begin n_fail++; $display("FAIL wr_wait_dout: got %h want 7f7f", dout); end
        rdv = 1'b1;
        cyc();
        n_checks++; if (dout !== 16'hCAFE) begin n_fail++; $display("FAIL wr_dout: got %h want cafe", dout); end
        repeat (2) cyc();
    endtask

    task automatic test_pause();
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pulse_tick();
            n_checks++; if (rd !== 1'b0) begin n_fail++; $display("FAIL pause_read[%0d]: got %b want 0", k, rd); end
            repeat (3) cyc();
        end
        n_checks++; if (addr !== 23'd2) begin n_fail++; $display("FAIL pause_addr: got %h want 2", addr); end
        n_checks++; if (dout !== 16'hCAFE) begin n_fail++; $display("FAIL pause_dout: got %h want cafe", dout); end
        pause = 1'b0;
        pulse_tick();
        n_checks++; if (rd !== 1'b1 || addr !== 23'd2) begin
            n_fail++; $display("FAIL pause_release: got read=%b addr=%h want read=1 addr=2", rd, addr);
        end
        repeat (2) cyc();
        n_checks++; if (dout !== 16'hBEEF) begin n_fail++; $display("FAIL pause_release_dout: got %h want beef", dout); end
        n_checks++; if (addr !== 23'd3) begin n_fail++; $display("FAIL pause_release_addr: got %h want 3", addr); end
        repeat (2) cyc();
    endtask

    task automatic test_backward();
        do_reset();
        direction = 1'b0; rdata = 32'hAAAA_5555;
        pulse_tick();
        n_checks++; if (addr !== 23'd0) begin n_fail++; $display("FAIL bwd_addr0: got %h want 0", addr); end
        repeat (2) cyc();
        n_checks++; if (dout !== 16'h5555) begin n_fail++; $display("FAIL bwd_dout0: got %h want 5555", dout); end
        n_checks++; if (addr !== MaxAddr) begin n_fail++; $display("FAIL bwd_wrap: got %h want %h", addr, MaxAddr); end
        repeat (2) cyc();
        pulse_tick();
        n_checks++; if (addr !== MaxAddr) begin n_fail++; $display("FAIL bwd_addr1: got %h want %h", addr, MaxAddr); end
        repeat (2) cyc();
        n_checks++; if (dout !== 16'hAAAA) begin n_fail++; $display("FAIL bwd_dout1: got %h want aaaa", dout); end
        n_checks++; if (addr !== MaxAddr) begin n_fail++; $display("FAIL bwd_addr_end: got %h want %h", addr, MaxAddr); end
        repeat (2) cyc();
    endtask

    task automatic test_wrap_forward();
        do_reset();
        direction = 1'b0; rdata = 32'h1111_2222;
        pulse_tick();
        repeat (2) cyc();
        n_checks++; if (dout !== 16'h2222 || addr !== MaxAddr) begin
            n_fail++; $display("FAIL wrapf_setup: got dout=%h addr=%h want 2222 %h", dout, addr, MaxAddr);
        end
        direction = 1'b1; rdata = 32'h3333_4444;
        repeat (2) cyc();
        pulse_tick();
        n_checks++; if (addr !== MaxAddr) begin n_fail++; $display("FAIL wrapf_addr: got %h want %h", addr, MaxAddr); end
        repeat (2) cyc();
        n_checks++; if (dout !== 16'h3333) begin n_fail++; $display("FAIL wrapf_dout: got %h want 3333", dout); end
        n_checks++; if (addr !== 23'd0) begin n_fail++; $display("FAIL wrapf_wrap: got %h want 0", addr); end
        repeat (2) cyc();
        pulse_tick();
        repeat (2) cyc();
        n_checks++; if (dout !== 16'h4444 || addr !== 23'd0) begin
            n_fail++; $display("FAIL wrapf_next: got dout=%h addr=%h want 4444 0", dout, addr);
        end
        repeat (2) cyc();
    endtask

    task automatic test_reset_midread();
        direction = 1'b1; rdv = 1'b1; wreq = 1'b0; rdata = 32'h5555_6666;
        pulse_tick();
        repeat (2) cyc();
        n_checks++; if (dout !== 16'h5555 || addr !== 23'd1) begin
            n_fail++; $display("FAIL midrst_setup: got dout=%h addr=%h want 5555 1", dout, addr);
        end
        rdv = 1'b0;
        repeat (2) cyc();
        pulse_tick();
        cyc();
        n_checks++; if (rd !== 1'b0 || addr !== 23'd1) begin
            n_fail++; $display("FAIL midrst_wait: got read=%b addr=%h want 0 1", rd, addr);
        end
        reset = 1'b1; rdv = 1'b1;
        cyc();
        reset = 1'b0;
        n_checks++; if (rd !== 1'b0 || addr !== 23'd0 || dout !== 16'h0) begin
            n_fail++; $display("FAIL midrst_clear: got read=%b addr=%h dout=%h want 0 0 0", rd, addr, dout);
        end
        repeat (3) cyc();
        n_checks++; if (rd !== 1'b0 || addr !== 23'd0 || dout !== 16'h0) begin
            n_fail++; $display("FAIL midrst_late_valid: got read=%b addr=%h dout=%h want 0 0 0", rd, addr, dout);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_waitrequest();
        test_pause();
        test_backward();
        test_wrap_forward();
        test_reset_midread();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
